// File: rtl/id_stage.sv
// Decode stage: holds one instruction, reads its operands from the register file,
// keeps them coherent with writeback, and hands a decoded payload to execute.
module id_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic            ex_illegal,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7
);

  localparam int unsigned RW = 5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {S_EMPTY, S_ISSUE, S_WAIT, S_FULL} state_t;

  state_t        state;
  logic [RW-1:0] rs1, rs2;
  logic          accept, suppressed, fwd1, fwd2;
  logic [XLEN-1:0] dec_imm;
  logic          dec_illegal, dec_no_wr, dec_rd_we;

  // Handshakes and register-file addressing
  always_comb begin
    if_ready   = rstn && !flush &&
                 ((state == S_EMPTY) || ((state == S_FULL) && ex_ready));
    accept     = if_valid && if_ready;
    ex_valid   = rstn && (state == S_FULL);
    ra1        = accept ? if_instr[19:15] : rs1;
    ra2        = accept ? if_instr[24:20] : rs2;
    suppressed = wb_we && ((wb_rd == ra1) || (wb_rd == ra2));
    fwd1       = wb_we && (wb_rd == rs1) && (rs1 != '0);
    fwd2       = wb_we && (wb_rd == rs2) && (rs2 != '0);
  end

  // Immediate and class decode of the incoming instruction
  always_comb begin
    dec_imm     = '0;
    dec_illegal = 1'b0;
    dec_no_wr   = 1'b0;
    case (if_instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        dec_imm = {{20{if_instr[31]}}, if_instr[31:20]};
      OP_STORE: begin
        dec_imm   = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
        dec_no_wr = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm   = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                     if_instr[30:25], if_instr[11:8], 1'b0};
        dec_no_wr = 1'b1;
      end
      OP_LUI, OP_AUIPC:
        dec_imm = {if_instr[31:12], 12'b0};
      OP_JAL:
        dec_imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                   if_instr[20], if_instr[30:21], 1'b0};
      OP_REG, OP_FENCE, OP_SYSTEM: ;
      default: dec_illegal = 1'b1;
    endcase
    dec_rd_we = !dec_no_wr && !dec_illegal && (if_instr[11:7] != '0);
  end

  // Slot state machine with operand capture and writeback forwarding
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_EMPTY;
      rs1        <= '0;
      rs2        <= '0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rd      <= '0;
      ex_rd_we   <= 1'b0;
      ex_illegal <= 1'b0;
      ex_opcode  <= '0;
      ex_funct3  <= '0;
      ex_funct7  <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
    end else if (accept) begin
      state      <= suppressed ? S_ISSUE : S_WAIT;
      rs1        <= if_instr[19:15];
      rs2        <= if_instr[24:20];
      ex_pc      <= if_pc;
      ex_imm     <= dec_imm;
      ex_rd      <= if_instr[11:7];
      ex_rd_we   <= dec_rd_we;
      ex_illegal <= dec_illegal;
      ex_opcode  <= if_instr[6:0];
      ex_funct3  <= if_instr[14:12];
      ex_funct7  <= if_instr[31:25];
    end else begin
      case (state)
        S_ISSUE: if (!suppressed) state <= S_WAIT;
        S_WAIT: begin
          state      <= S_FULL;
          ex_rs1_val <= (rs1 == '0) ? '0 : (fwd1 ? wb_wd : rd1);
          ex_rs2_val <= (rs2 == '0) ? '0 : (fwd2 ? wb_wd : rd2);
        end
        S_FULL: begin
          if (ex_ready) begin
            state <= S_EMPTY;
          end else begin
            if (fwd1) ex_rs1_val <= wb_wd;
            if (fwd2) ex_rs2_val <= wb_wd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a randomized stream checked
// against an architectural register array and an in-order instruction queue.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rstn, flush, if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wd;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_rd_we, ex_illegal;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;
  txn_t q[$];

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_illegal(ex_illegal),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7)
  );

  always #5 clk = ~clk;

  // Register file environment: one-edge read latency, reads blocked on write conflict
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (!(wb_we && ((wb_rd == ra1) || (wb_rd == ra2)))) begin
        rd1 <= rf[ra1];
        rd2 <= rf[ra2];
      end
      if (wb_we && (wb_rd != 5'd0)) rf[wb_rd] <= wb_wd;
    end
  end

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(i[31:20]));
      7'h23:               return 32'($signed({i[31:25], i[11:7]}));
      7'h63:               return 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      7'h37, 7'h17:        return {i[31:12], 12'h000};
      7'h6F:               return 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
      7'h33, 7'h0F, 7'h73: return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

  function automatic logic ref_rd_we(input logic [31:0] i);
    return !(ref_illegal(i) || i[6:0] == 7'h23 || i[6:0] == 7'h63 || i[11:7] == 5'd0);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0: w[6:0] = 7'h13;  1: w[6:0] = 7'h03;  2: w[6:0] = 7'h67;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6F;  8: w[6:0] = 7'h33;
      9: w[6:0] = 7'h0F; 10: w[6:0] = 7'h73;
      default: w[6:0] = 7'($urandom);
    endcase
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_wd = '0;
    if_instr = '0; if_pc = '0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    wb_we = 1'b1; wb_rd = r; wb_wd = v;
    tick();
    wb_we = 1'b0;
  endtask

  // Offer one instruction from EMPTY; lat = edges from accept until ex_valid (10 = timeout)
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, output int lat);
    if_valid = 1'b1; if_instr = instr; if_pc = pc;
    tick();
    if_valid = 1'b0;
    lat = 1;
    while (!ex_valid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle(); if_valid = 1'b1; if_instr = 32'h00A00093; ex_ready = 1'b1;
    #1;
    n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL rst_if_ready got=%b exp=0", if_ready); end
    tick(); tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
    n_checks++; if ({ra1, ra2} !== 10'd0) begin n_fail++; $display("FAIL rst_ra got=%h exp=0", {ra1, ra2}); end
    n_checks++; if ({ex_pc, ex_imm, ex_rs1_val, ex_rs2_val} !== 128'd0) begin n_fail++; $display("FAIL rst_payload got=%h exp=0", {ex_pc, ex_imm, ex_rs1_val, ex_rs2_val}); end
    n_checks++; if ({ex_rd, ex_rd_we, ex_illegal, ex_opcode, ex_funct3, ex_funct7} !== 24'd0) begin n_fail++; $display("FAIL rst_fields got=%h exp=0", {ex_rd, ex_rd_we, ex_illegal, ex_opcode, ex_funct3, ex_funct7}); end
    if_valid = 1'b0; rstn = 1'b1;
    #1;
    n_checks++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=1", if_ready); end
  endtask

  task automatic test_addi();
    int lat;
    ex_ready = 1'b1;
    issue(32'h00A00093, 32'h100, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL addi_latency got=%0d exp=2", lat); end
    n_checks++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got=%h exp=100", ex_pc); end
    n_checks++; if (ex_imm !== 32'd10) begin n_fail++; $display("FAIL addi_imm got=%h exp=a", ex_imm); end
    n_checks++; if (ex_rs1_val !== 32'd0) begin n_fail++; $display("FAIL addi_rs1 got=%h exp=0", ex_rs1_val); end
    n_checks++; if (ex_rd !== 5'd1 || ex_rd_we !== 1'b1) begin n_fail++; $display("FAIL addi_rd got=%0d/%b exp=1/1", ex_rd, ex_rd_we); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got=%b exp=0", ex_valid); end
  endtask

  task automatic test_suppress();
    int lat;
    ex_ready = 1'b0;
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd7);
    if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h200;
    wb_we = 1'b1; wb_rd = 5'd2; wb_wd = 32'd9;
    tick();
    if_valid = 1'b0; wb_we = 1'b0;
    lat = 1;
    while (!ex_valid && lat < 10) begin tick(); lat++; end
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL supp_latency got=%0d exp=3", lat); end
    n_checks++; if (ex_rs1_val !== 32'd5) begin n_fail++; $display("FAIL supp_rs1 got=%h exp=5", ex_rs1_val); end
    n_checks++; if (ex_rs2_val !== 32'd9) begin n_fail++; $display("FAIL supp_rs2 got=%h exp=9", ex_rs2_val); end
    n_checks++; if (ex_rd !== 5'd3 || ex_rd_we !== 1'b1 || ex_illegal !== 1'b0) begin n_fail++; $display("FAIL supp_rd got=%0d/%b/%b exp=3/1/0", ex_rd, ex_rd_we, ex_illegal); end
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;
  endtask

  task automatic test_forward();
    int lat;
    ex_ready = 1'b0;
    wb_write(5'd6, 32'h66);
    issue(32'h006202B3, 32'h300, lat);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL fwd_latency got=%0d exp=2", lat); end
    wb_we = 1'b1; wb_rd = 5'd4; wb_wd = 32'hDEAD;
    tick();
    wb_we = 1'b0;
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid got=%b exp=1", ex_valid); end
    n_checks++; if (ex_rs1_val !== 32'hDEAD) begin n_fail++; $display("FAIL fwd_rs1 got=%h exp=dead", ex_rs1_val); end
    n_checks++; if (ex_rs2_val !== 32'h66) begin n_fail++; $display("FAIL fwd_rs2 got=%h exp=66", ex_rs2_val); end
    n_checks++; if (ex_pc !== 32'h300 || ex_imm !== 32'd0) begin n_fail++; $display("FAIL fwd_pc_imm got=%h/%h exp=300/0", ex_pc, ex_imm); end
    n_checks++; if ({ex_rd, ex_rd_we, ex_illegal, ex_opcode} !== {5'd5, 1'b1, 1'b0, 7'h33}) begin n_fail++; $display("FAIL fwd_fields got=%h exp=%h", {ex_rd, ex_rd_we, ex_illegal, ex_opcode}, {5'd5, 1'b1, 1'b0, 7'h33}); end
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;
  endtask

  task automatic test_decode();
    logic [31:0] ins [3];
    logic [31:0] imm [3];
    logic        we [3];
    logic        ill [3];
    int lat;
    ins[0] = 32'h00112423; imm[0] = 32'd8;        we[0] = 1'b0; ill[0] = 1'b0;
    ins[1] = 32'hFE000EE3; imm[1] = 32'hFFFFFFFC; we[1] = 1'b0; ill[1] = 1'b0;
    ins[2] = 32'h00000FFF; imm[2] = 32'd0;        we[2] = 1'b0; ill[2] = 1'b1;
    ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(ins[k], 32'h700 + 32'(k * 4), lat);
      n_checks++; if (ex_imm !== imm[k]) begin n_fail++; $display("FAIL dec%0d_imm got=%h exp=%h", k, ex_imm, imm[k]); end
      n_checks++; if (ex_rd_we !== we[k] || ex_illegal !== ill[k]) begin n_fail++; $display("FAIL dec%0d_flags got=%b/%b exp=%b/%b", k, ex_rd_we, ex_illegal, we[k], ill[k]); end
      ex_ready = 1'b1; tick(); ex_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0, hs = 0, first = -1, last = -1;
    ex_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if_valid = (idx < 4);
      if_instr = (32'(idx + 1) << 20) | (32'(idx + 1) << 7) | 32'h13;
      if_pc    = 32'h400 + 32'(idx * 4);
      #1;
      if (ex_valid && ex_ready) begin
        n_checks++; if (ex_pc !== 32'h400 + 32'(hs * 4) || ex_imm !== 32'(hs + 1)) begin n_fail++; $display("FAIL b2b_order%0d got=%h/%h exp=%h/%h", hs, ex_pc, ex_imm, 32'h400 + 32'(hs * 4), 32'(hs + 1)); end
        hs++;
        if (hs == 4) last = c;
      end
      if (if_valid && if_ready) begin
        if (idx == 0) first = c;
        idx++;
      end
      tick();
    end
    if_valid = 1'b0;
    n_checks++; if (hs != 4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", hs); end
    n_checks++; if (last - first != 8) begin n_fail++; $display("FAIL b2b_span got=%0d exp=8", last - first); end
  endtask

  task automatic test_flush_reset();
    int lat;
    for (int mode = 0; mode < 2; mode++) begin
      for (int where = 0; where < 2; where++) begin
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instr = 32'h00500113; if_pc = 32'h500;
        tick();
        if_valid = 1'b0;
        if (where == 1) tick();
        if_valid = 1'b1; if_instr = 32'h00700193; if_pc = 32'h540; ex_ready = 1'b1;
        if (mode == 0) flush = 1'b1; else rstn = 1'b0;
        #1;
        n_checks++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL fr%0d%0d_if_ready got=%b exp=0", mode, where, if_ready); end
        tick();
        flush = 1'b0; rstn = 1'b1; if_valid = 1'b0; ex_ready = 1'b0;
        #1;
        n_checks++; if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin n_fail++; $display("FAIL fr%0d%0d_empty got=%b/%b exp=0/1", mode, where, ex_valid, if_ready); end
        n_checks++; if (ex_pc !== ((mode == 0) ? 32'h500 : 32'h0)) begin n_fail++; $display("FAIL fr%0d%0d_payload got=%h exp=%h", mode, where, ex_pc, (mode == 0) ? 32'h500 : 32'h0); end
        issue(32'hFFF00393, 32'h600, lat);
        n_checks++; if (lat != 2 || ex_pc !== 32'h600 || ex_imm !== 32'hFFFFFFFF || ex_rd !== 5'd7 || ex_rd_we !== 1'b1) begin n_fail++; $display("FAIL fr%0d%0d_next got=%0d/%h/%h/%0d/%b exp=2/600/ffffffff/7/1", mode, where, lat, ex_pc, ex_imm, ex_rd, ex_rd_we); end
        ex_ready = 1'b1; tick(); ex_ready = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    txn_t t;
    logic [31:0] e1, e2;
    int drain = 0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      if (c < 560) begin
        ex_ready = ($urandom % 4) != 0;
        if_valid = $urandom % 2;
        if_instr = rand_instr();
        if_pc    = $urandom & 32'hFFFF_FFFC;
        wb_we    = ($urandom % 3) == 0;
        wb_rd    = 5'($urandom_range(0, 7));
        wb_wd    = $urandom;
      end else begin
        ex_ready = 1'b1; if_valid = 1'b0; wb_we = 1'b0;
        drain++;
      end
      #1;
      if (ex_valid && ex_ready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rnd_spurious pc=%h exp=none", ex_pc);
        end else begin
          t  = q.pop_front();
          e1 = rf[t.instr[19:15]];
          e2 = rf[t.instr[24:20]];
          n_checks++; if (ex_pc !== t.pc) begin n_fail++; $display("FAIL rnd_pc got=%h exp=%h", ex_pc, t.pc); end
          n_checks++; if (ex_imm !== ref_imm(t.instr)) begin n_fail++; $display("FAIL rnd_imm ins=%h got=%h exp=%h", t.instr, ex_imm, ref_imm(t.instr)); end
          n_checks++; if (ex_rs1_val !== e1 || ex_rs2_val !== e2) begin n_fail++; $display("FAIL rnd_ops ins=%h got=%h/%h exp=%h/%h", t.instr, ex_rs1_val, ex_rs2_val, e1, e2); end
          n_checks++; if (ex_rd !== t.instr[11:7] || ex_rd_we !== ref_rd_we(t.instr) || ex_illegal !== ref_illegal(t.instr)) begin n_fail++; $display("FAIL rnd_dest ins=%h got=%0d/%b/%b exp=%0d/%b/%b", t.instr, ex_rd, ex_rd_we, ex_illegal, t.instr[11:7], ref_rd_we(t.instr), ref_illegal(t.instr)); end
          n_checks++; if ({ex_opcode, ex_funct3, ex_funct7} !== {t.instr[6:0], t.instr[14:12], t.instr[31:25]}) begin n_fail++; $display("FAIL rnd_fields ins=%h got=%h", t.instr, {ex_opcode, ex_funct3, ex_funct7}); end
        end
      end
      if (if_valid && if_ready) q.push_back('{pc: if_pc, instr: if_instr});
      tick();
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_leftover got=%0d exp=0", q.size()); end
    ex_ready = 1'b0;
  endtask

  initial begin
    idle();
    rstn = 1'b0; ex_ready = 1'b0;
    test_reset();
    test_addi();
    test_suppress();
    test_forward();
    test_decode();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Port: clk  in  1  rising-edge clock, the only clock.
REQ-003 Port: rstn  in  1  synchronous active-low reset.
REQ-004 Port: flush  in  1  synchronous discard of the held instruction.
REQ-005 Port: if_valid/if_ready  in/out  1/1  fetch handshake.
REQ-006 Port: if_instr/if_pc  in  32/32  instruction word and its PC.
REQ-007 Port: ra1/ra2  out  5/5  register-file read addresses.
REQ-008 Port: rd1/rd2  in  32/32  register-file read data, valid one edge after ra1/ra2 are presented.
REQ-009 Port: wb_we/wb_rd/wb_wd  in  1/5/32  write port, the same signals that drive the register file.
REQ-010 Port: ex_valid/ex_ready  out/in  1/1  execute handshake.
REQ-011 Port: ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  decoded payload.
REQ-012 Port: ex_rd/ex_rd_we/ex_illegal  out  5/1/1  destination, write flag, unknown-opcode flag.
REQ-013 Port: ex_opcode/ex_funct3/ex_funct7  out  7/3/7  raw instruction fields.

Function
REQ-014 States: EMPTY, ISSUE (slot loaded, read must be presented), WAIT (read in flight), FULL (operands valid).
REQ-015 Accept is if_valid&&if_ready.
- if_ready = (state==EMPTY) || (state==FULL && ex_ready) while flush=0; else 0.
REQ-016 ra1/ra2:
- On accept: if_instr[19:15]/[24:20].
- Otherwise: held slot rs1/rs2.
REQ-017 A read is "suppressed" in a cycle when wb_we=1 and wb_rd equals ra1 or ra2. The register file then updates neither rd1 nor rd2.
REQ-018 Read completion:
- Accept or ISSUE with read not suppressed goes to WAIT.
- Accept or ISSUE with read suppressed goes to ISSUE.
- ISSUE re-presents slot addresses until a cycle is unsuppressed.
REQ-019 WAIT -> FULL on the next edge, capturing both operands:
- opN <= 0 if rsN==0.
- else wb_wd if wb_we && wb_rd==rsN.
- else rdN.
REQ-020 In FULL without handshake, opN <= wb_wd whenever wb_we && wb_rd==rsN && rsN!=0. Other payload is held stable.
REQ-021 ex_valid=1 only in FULL. ex_rs1_val/ex_rs2_val come directly from op1/op2 registers.
REQ-022 FULL with ex_valid&&ex_ready:
- With same-cycle accept: goes to WAIT or ISSUE per REQ-018.
- Without accept: goes to EMPTY.
- Sustained throughput is one instruction per 2 cycles; min accept-to-ex_valid latency is 2 edges.
REQ-023 Immediate from opcode, sign-extended to 32 bits:
- I-type (0010011, 0000011, 1100111).
- S-type (0100011).
- B-type (1100011).
- U-type (0110111, 0010111).
- J-type (1101111).
- All other opcodes: 0.
REQ-024 Destination:
- ex_rd = instr[11:7].
- ex_rd_we = 0 for S, B, illegal, or rd==0; else 1.
REQ-025 ex_illegal=1 for any opcode outside REQ-023 plus 0110011, 0001111, 1110011.
- The instruction still flows through with ex_rd_we=0.
REQ-026 Flush:
- flush=1 at an edge forces EMPTY regardless of ex_ready.
- Any same-cycle if_valid is not accepted (if_ready=0).
- Payload registers keep their values.
REQ-027 Priority: rstn low > flush > handshake/forwarding.

Reset
REQ-028 rstn=0 at an edge forces the following, regardless of other inputs, including mid-WAIT/ISSUE:
- State EMPTY.
- All slot fields and op registers 0.
- ex_valid=0, if_ready=0 while rstn=0.
REQ-029 After reset, outputs are ra1=ra2=0, ex_*=0.
- The first accept is possible in the first cycle with rstn=1.

Verification
REQ-030 Reset, then if_instr=0x00A00093 (addi x1,x0,10), PC 0x100; ex_ready=1 -> 2 edges later:
- ex_valid=1, ex_pc=0x100, ex_imm=10, ex_rs1_val=0, ex_rd=1, ex_rd_we=1.
REQ-031 Accept add x3,x1,x2 (0x002081B3) with x1=5, x2=7. Same cycle wb_we=1, wb_rd=2, wb_wd=9 -> read suppressed, ISSUE for one cycle:
- ex_valid 3 edges after accept.
- ex_rs1_val=5, ex_rs2_val=9.
REQ-032 FULL with ex_ready=0 holding rs1=4; write x4=0xDEAD via wb -> next edge ex_rs1_val=0xDEAD, all other payload unchanged.
REQ-033 sw (0x00112423) -> ex_imm=8, ex_rd_we=0. beq -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC. Opcode 0x7F -> ex_illegal=1, ex_rd_we=0.
REQ-034 Back-to-back stream of 4 instructions with ex_ready=1 -> 4 ex handshakes in 8 cycles, in order, no loss or duplication.
REQ-035 Flush, then separately rstn=0, each asserted in WAIT and in FULL -> next edge EMPTY, ex_valid=0. The next accepted instruction decodes correctly.
